// File: rtl/axi_bram2axis.sv
// Streams BRAM words 0..depth-1 out as AXI4-Stream beats. A credit-gated output
// FIFO absorbs the fixed BRAM read latency so a beat can leave every cycle.
module axi_bram2axis #(
  parameter int AXI_DATA_WIDTH      = 512,
  parameter int AXI_XFER_SIZE_WIDTH = 32,
  parameter int BRAM_ADDR_WIDTH     = 32,
  parameter int BRAM_DATA_WIDTH     = 512,
  parameter int BRAM_DELAY          = 2,
  parameter int FIFO_DEPTH          = BRAM_DELAY + 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_bs2a_start,
  output logic                           o_bs2a_done,
  input  logic [AXI_XFER_SIZE_WIDTH-1:0] i_bs2a_data_size_bytes,
  output logic                           o_bs2a_rden,
  output logic [BRAM_ADDR_WIDTH-1:0]     o_bs2a_rdaddr,
  input  logic [BRAM_DATA_WIDTH-1:0]     i_bs2a_rddata,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic [AXI_DATA_WIDTH-1:0]      m_axis_tdata,
  output logic                           m_axis_tlast
);
  localparam int CW = BRAM_ADDR_WIDTH + 1;
  localparam int SW = AXI_XFER_SIZE_WIDTH + 3;
  localparam int WW = (SW > CW) ? SW : CW;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                    state_q, state_d;
  logic [CW-1:0]             depth_q, depth_d;
  logic [CW-1:0]             rd_cnt_q, rd_cnt_d;
  logic [CW-1:0]             tx_cnt_q, tx_cnt_d;
  logic [BRAM_DELAY-1:0]     vld_q, vld_d;
  logic [PW-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FW-1:0]             cnt_q, cnt_d;
  logic [AXI_DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic                      push, pop, credit;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Credit counts in-flight reads as already occupying FIFO slots, so no read
  // is issued unless its data is guaranteed a place to land.
  assign credit        = (32'(cnt_q) + 32'($countones(vld_q))) < 32'(FIFO_DEPTH);
  assign o_bs2a_rden   = (state_q == BUSY) && (rd_cnt_q < depth_q) && credit;
  assign o_bs2a_rdaddr = rd_cnt_q[BRAM_ADDR_WIDTH-1:0];
  assign o_bs2a_done   = (state_q == IDLE);
  assign push          = vld_q[BRAM_DELAY-1];
  assign m_axis_tvalid = (cnt_q != '0);
  assign m_axis_tdata  = mem_q[rd_ptr_q];
  assign m_axis_tlast  = m_axis_tvalid && (tx_cnt_q == depth_q - CW'(1));
  assign pop           = m_axis_tvalid && m_axis_tready;

  always_comb begin
    state_d  = state_q;
    depth_d  = depth_q;
    rd_cnt_d = rd_cnt_q;
    tx_cnt_d = tx_cnt_q;
    vld_d    = BRAM_DELAY'({vld_q, o_bs2a_rden});
    wr_ptr_d = push ? nxt(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? nxt(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (push && !pop) cnt_d = cnt_q + FW'(1);
    if (!push && pop) cnt_d = cnt_q - FW'(1);
    unique case (state_q)
      IDLE: if (i_bs2a_start) begin
        state_d  = BUSY;
        depth_d  = CW'(WW'({i_bs2a_data_size_bytes, 3'b000}) / WW'(BRAM_DATA_WIDTH));
        rd_cnt_d = '0;
        tx_cnt_d = '0;
      end
      BUSY: begin
        if (o_bs2a_rden) rd_cnt_d = rd_cnt_q + CW'(1);
        if (pop)         tx_cnt_d = tx_cnt_q + CW'(1);
        if (tx_cnt_q == depth_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      depth_q  <= '0;
      rd_cnt_q <= '0;
      tx_cnt_q <= '0;
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      depth_q  <= depth_d;
      rd_cnt_q <= rd_cnt_d;
      tx_cnt_q <= tx_cnt_d;
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_ptr_q] <= i_bs2a_rddata;
  end

  always_ff @(posedge clk) begin
    if (!rst && push && !pop) assert (cnt_q != FW'(FIFO_DEPTH));
  end
endmodule

// File: tb/tb_axi_bram2axis.sv
// Directed bench for axi_bram2axis: a table of transfers plus a mid-transfer
// reset sequence, against a BRAM model with a fixed read latency.
module tb_axi_bram2axis;
  localparam int DW = 512;
  localparam int D  = 2;
  localparam int FD = D + 2;

  logic          clk = 0, rst = 1, start = 0, done, rden, tvalid, tready = 0, tlast;
  logic [31:0]   size_in = '0, rdaddr;
  logic [DW-1:0] rddata, tdata;

  axi_bram2axis dut (
    .clk(clk), .rst(rst), .i_bs2a_start(start), .o_bs2a_done(done),
    .i_bs2a_data_size_bytes(size_in), .o_bs2a_rden(rden), .o_bs2a_rdaddr(rdaddr),
    .i_bs2a_rddata(rddata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
    .m_axis_tdata(tdata), .m_axis_tlast(tlast)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] word(input logic [31:0] a);
    return {16{32'hC0DE0000 + a}};
  endfunction

  // BRAM model: keeps delivering across DUT reset so late data must be dropped.
  logic [D-1:0] bv = '0;
  logic [31:0]  ba [D];
  always @(posedge clk) begin
    bv    <= {bv[D-2:0], rden};
    ba[0] <= rdaddr;
    for (int i = 1; i < D; i++) ba[i] <= ba[i-1];
  end
  assign rddata = bv[D-1] ? word(ba[D-1]) : {16{32'hDEADBEEF}};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [DW-1:0] d; logic l; int c; } beat_t;
  beat_t       beat_q[$];
  logic [31:0] rd_q[$];
  logic        mon_clr = 0;
  int          n_out = 0, max_out = 0, stall_bad = 0;
  logic        pv = 0, pr = 0, pl = 0;
  logic [DW-1:0] pd = '0;

  always @(negedge clk) begin
    if (mon_clr) begin
      beat_q.delete(); rd_q.delete();
      n_out <= 0; max_out <= 0; stall_bad <= 0;
    end else begin
      if (rden) rd_q.push_back(rdaddr);
      if (tvalid && tready) beat_q.push_back('{tdata, tlast, cyc});
      n_out <= n_out + int'(rden) - int'(tvalid && tready);
      if (n_out + int'(rden) > max_out) max_out <= n_out + int'(rden);
      if (!rst && pv && !pr && (!tvalid || tdata !== pd || tlast !== pl))
        stall_bad <= stall_bad + 1;
    end
    pv <= tvalid; pr <= tready; pd <= tdata; pl <= tlast;
  end

  int total = 0, bad = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  int first_v, busy, done_cyc, rd_at_hold, timeout;
  logic rden_at_hold;

  task automatic run_xfer(input int size, input logic [3:0] mask, input bit restart, input int hold);
    int n;
    size_in = size; start = 1; mon_clr = 1; tready = 0;
    tick();
    start = 0; mon_clr = 0; size_in = 32'hFFFF_FFC0;
    n = 0; first_v = -1; timeout = 0; rd_at_hold = -1; rden_at_hold = 1'bx;
    while (!done && n < 2000) begin
      tready = (n < hold) ? 1'b0 : mask[n % 4];
      start  = restart && (n == 1);
      tick();
      start = 0;
      n++;
      if (tvalid && first_v < 0) first_v = n;
      if (n == hold) begin rd_at_hold = rd_q.size(); rden_at_hold = rden; end
    end
    busy = n; done_cyc = cyc; timeout = (n >= 2000);
    tready = 0;
  endtask

  task automatic chk_xfer(input int exp, input int exp_busy, input int hold);
    int abad, dbad, lbad;
    abad = 0; dbad = 0; lbad = 0;
    chk("xfer timeout", timeout, 0);
    chk("beat count", beat_q.size(), exp);
    chk("read count", rd_q.size(), exp);
    for (int i = 0; i < rd_q.size(); i++) if (rd_q[i] !== 32'(i)) abad++;
    for (int i = 0; i < beat_q.size(); i++) begin
      if (beat_q[i].d !== word(32'(i))) dbad++;
      if (beat_q[i].l !== (i == exp - 1)) lbad++;
    end
    chk("rdaddr order", abad, 0);
    chk("beat data", dbad, 0);
    chk("tlast placement", lbad, 0);
    chk("stall stability", stall_bad, 0);
    chk("outstanding<=FIFO_DEPTH", max_out <= FD, 1);
    if (exp > 0 && beat_q.size() == exp) begin
      // tvalid appears D+1 edges after the edge that sampled start
      if (hold == 0) chk("first tvalid latency", first_v, D + 1);
      chk("done after last beat", done_cyc - beat_q[exp-1].c, 2);
    end
    if (exp == 0) chk("no tvalid", first_v, -1);
    if (exp_busy > 0) chk("busy cycles", busy, exp_busy);
    if (hold > 0) begin
      chk("reads during stall", rd_at_hold, FD);
      chk("rden low during stall", rden_at_hold, 0);
    end
  endtask

  task automatic chk_consec(input int exp);
    if (beat_q.size() == exp && exp > 0)
      chk("back-to-back beats", beat_q[exp-1].c - beat_q[0].c, exp - 1);
  endtask

  typedef struct { int size; logic [3:0] mask; bit restart; int hold; int exp_beats; int exp_busy; } vec_t;
  vec_t tbl[8];

  initial begin
    tbl[0] = '{256,  4'hF, 1'b0, 0,  4,  0};
    tbl[1] = '{640,  4'h9, 1'b0, 0,  10, 0};  // ready 1,0,0,1 repeating
    tbl[2] = '{0,    4'hF, 1'b0, 0,  0,  1};
    tbl[3] = '{32,   4'hF, 1'b0, 0,  0,  1};  // below one word
    tbl[4] = '{1024, 4'hF, 1'b0, 20, 16, 0};  // held off 20 cycles
    tbl[5] = '{256,  4'hF, 1'b1, 0,  4,  0};  // start re-pulsed while busy
    tbl[6] = '{100,  4'hF, 1'b0, 0,  1,  0};  // 800 bits -> 1 word
    tbl[7] = '{1024, 4'h3, 1'b0, 0,  16, 0};

    rst = 1;
    repeat (3) tick();
    rst = 0;
    tick();
    chk("reset done", done, 1);
    chk("reset rden", rden, 0);
    chk("reset rdaddr", rdaddr, 0);
    chk("reset tvalid", tvalid, 0);
    chk("reset tlast", tlast, 0);

    for (int i = 0; i < 8; i++) begin
      run_xfer(tbl[i].size, tbl[i].mask, tbl[i].restart, tbl[i].hold);
      chk_xfer(tbl[i].exp_beats, tbl[i].exp_busy, tbl[i].hold);
      if (tbl[i].mask == 4'hF) chk_consec(tbl[i].exp_beats);
      repeat (2) tick();
    end

    // Reset with two reads in flight, then a clean 128-byte transfer.
    size_in = 1024; start = 1; tready = 1;
    tick();
    start = 0;
    tick();
    tick();
    chk("inflight before reset", $countones(bv), 2);
    rst = 1;
    tick();
    chk("abort done", done, 1);
    chk("abort rden", rden, 0);
    chk("abort rdaddr", rdaddr, 0);
    chk("abort tvalid", tvalid, 0);
    chk("abort tlast", tlast, 0);
    rst = 0;
    run_xfer(128, 4'hF, 1'b0, 0);
    chk_xfer(2, 0, 0);
    chk_consec(2);

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
